// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, parity-type codes and line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Loadable bit-period down-counter: load sets period-1, bit_done is high in the cycle the count sits at 0.
// Single-cycle response to load; period must be at least 1 (the caller clamps a zero prescale).
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      run,
    input  logic [PRESCALE_WIDTH-1:0] period,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = period - PRESCALE_WIDTH'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = run && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, one stop bit, PRESCALE clocks per bit.
// Line and Busy change one edge after accept; requests while Busy are dropped, so the source holds DATA_VALID until Busy rises.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      load;
    logic                      bit_done;
    logic [PRESCALE_WIDTH-1:0] presc_eff;
    logic [PRESCALE_WIDTH-1:0] period;

    assign presc_eff = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
    // On accept the latched prescale is not yet valid, so feed the timer straight from the port.
    assign period    = (state_q == ST_IDLE) ? presc_eff : presc_q;

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk      (CLK),
        .rst_n    (RSTn),
        .load     (load),
        .run      (state_q != ST_IDLE),
        .period   (period),
        .bit_done (bit_done)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= '0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        presc_d   = presc_q;
        load      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (DATA_VALID && !busy_q) begin
                    state_d   = ST_START;
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
                    presc_d   = presc_eff;
                    load      = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    load = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    load    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is decoded from the next state so TX_OUT lands on the same edge as the state change.
    always_comb begin
        tx_d   = LINE_IDLE;
        busy_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = LINE_IDLE;
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle comparison of TX_OUT/Busy against a frame-level reference model.
module tb_uart_tx_frame;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] PRESCALE;
    logic          TX_OUT;
    logic          Busy;

    uart_tx_frame #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the whole frame is expanded into per-cycle line levels at accept time.
    bit exp_q[$];
    bit exp_tx   = 1'b1;
    bit exp_busy = 1'b0;
    int mdl_p;
    int mdl_ones;

    always @(posedge CLK) begin
        if (RSTn !== 1'b1) begin
            exp_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else if (exp_q.size() > 0) begin
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
        end else if (exp_busy) begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else if (DATA_VALID === 1'b1) begin
            mdl_p    = (PRESCALE == 0) ? 1 : int'(PRESCALE);
            mdl_ones = $countones(P_DATA);
            for (int k = 0; k < mdl_p; k++) exp_q.push_back(1'b0);
            for (int b = 0; b < DW; b++)
                for (int k = 0; k < mdl_p; k++) exp_q.push_back(P_DATA[b]);
            if (PAR_EN)
                for (int k = 0; k < mdl_p; k++)
                    exp_q.push_back((mdl_ones % 2 == 1) ? !PAR_TYP : PAR_TYP);
            for (int k = 0; k < mdl_p; k++) exp_q.push_back(1'b1);
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
    end

    bit checking = 1'b0;
    int busy_cnt = 0;
    int rises    = 0;
    bit busy_prev = 1'b0;
    int hi_run   = 0;
    int last_hi  = 0;

    always @(negedge CLK) begin
        if (checking) begin
            check_eq("tx_out", TX_OUT, exp_tx);
            check_eq("busy", Busy, exp_busy);
        end
        if (Busy === 1'b1) busy_cnt++;
        if (Busy === 1'b1 && !busy_prev) rises++;
        busy_prev = (Busy === 1'b1);
        if (TX_OUT === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run > 0) last_hi = hi_run;
            hi_run = 0;
        end
    end

    task automatic req(input logic [DW-1:0] d, input bit pen, input bit ptyp, input logic [PW-1:0] ps);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        PRESCALE   = ps;
        DATA_VALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (Busy === 1'b1) break;
        end
        check_eq("accept_seen", Busy, 1'b1);
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (Busy === 1'b0) break;
            @(negedge CLK);
        end
        check_eq("idle_seen", Busy, 1'b0);
    endtask

    initial begin
        int gap;
        RSTn       = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        PRESCALE   = 6'd8;

        @(posedge CLK);
        checking = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("reset_tx", TX_OUT, 1'b1);
        check_eq("reset_busy", Busy, 1'b0);
        RSTn = 1'b1;
        repeat (5) @(negedge CLK);

        busy_cnt = 0; rises = 0;
        req(8'hA5, 1'b0, 1'b0, 6'd8);
        wait_idle();
        check_eq("a5_frame_len", busy_cnt, 80);

        busy_cnt = 0;
        req(8'h03, 1'b1, 1'b0, 6'd4);
        wait_idle();
        check_eq("even_frame_len", busy_cnt, 44);
        req(8'h03, 1'b1, 1'b1, 6'd4);
        wait_idle();

        rises = 0;
        req(8'h3C, 1'b0, 1'b0, 6'd8);
        repeat (20) @(negedge CLK);
        P_DATA = 8'hFF; PAR_EN = 1'b1; PRESCALE = 6'd2; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        wait_idle();
        repeat (10) @(negedge CLK);
        check_eq("ignored_req_frames", rises, 1);

        // Held request: second frame must start after stop bit plus one idle cycle.
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd8; DATA_VALID = 1'b1;
        for (int i = 0; i < 50 && Busy !== 1'b1; i++) @(negedge CLK);
        P_DATA = 8'h0F;
        for (int i = 0; i < 200 && Busy !== 1'b0; i++) @(negedge CLK);
        gap = 0;
        for (int i = 0; i < 50 && Busy !== 1'b1; i++) begin
            gap++;
            @(negedge CLK);
        end
        check_eq("b2b_busy_gap", gap, 1);
        @(negedge CLK);
        DATA_VALID = 1'b0;
        check_eq("b2b_line_high", last_hi, 9);
        wait_idle();

        req(8'hC3, 1'b0, 1'b0, 6'd8);
        repeat (34) @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        check_eq("midrst_tx", TX_OUT, 1'b1);
        check_eq("midrst_busy", Busy, 1'b0);
        RSTn = 1'b1;
        req(8'h5A, 1'b1, 1'b1, 6'd3);
        wait_idle();

        busy_cnt = 0;
        req(8'h81, 1'b1, 1'b1, 6'd0);
        wait_idle();
        check_eq("presc0_frame_len", busy_cnt, 11);
        busy_cnt = 0;
        req(8'h81, 1'b1, 1'b1, 6'd1);
        wait_idle();
        check_eq("presc1_frame_len", busy_cnt, 11);

        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                req(DW'($urandom), 1'($urandom), 1'($urandom), PW'($urandom_range(0, 6)));
                repeat ($urandom_range(1, 20)) @(negedge CLK);
                RSTn = 1'b0;
                @(negedge CLK);
                RSTn = 1'b1;
            end else begin
                req(DW'($urandom), 1'($urandom), 1'($urandom), PW'($urandom_range(0, 6)));
                if ($urandom_range(0, 3) == 0) begin
                    repeat (3) @(negedge CLK);
                    P_DATA = DW'($urandom);
                    DATA_VALID = 1'b1;
                    @(negedge CLK);
                    DATA_VALID = 1'b0;
                end
                wait_idle();
            end
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        repeat (5) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
